// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
//   WORD_W      : native datapath word width
//   RAM8_DEPTH  : word count of the small register bank
//   RAM64_DEPTH : word count of the larger RAM block
package cpu_pkg;

   localparam int unsigned WORD_W      = 16;
   localparam int unsigned RAM8_DEPTH  = 8;
   localparam int unsigned RAM64_DEPTH = 64;

endpackage : cpu_pkg

// File: rtl/reg_word.sv
// Single load register holding one data word and its valid bit.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears word and valid
//   clear  : synchronous clear of word and valid, wins over load
//   load   : capture in and set valid
//   in     : write data
//   q      : stored word
//   valid  : word has been written since the last reset/clear
module reg_word #(
   parameter int unsigned WIDTH = cpu_pkg::WORD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   logic [WIDTH-1:0] q_q;
   logic             valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         q_q     <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         q_q     <= in;
         valid_q <= 1'b1;
      end
   end

   assign q     = q_q;
   assign valid = valid_q;

endmodule : reg_word

// File: rtl/regfile_2r1w.sv
// Register file: one synchronous write port, two combinational read ports,
// synchronous clear-all, optional write-through bypass and per-word valid
// tracking with a count of valid words.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load, waddr, in   : write enable, address, data (out-of-range ignored)
//   clear             : synchronous clear of all words, wins over load
//   raddr_a, raddr_b  : read addresses
//   out_a, out_b      : read data (0 when out of range)
//   valid_a, valid_b  : valid bit of the addressed word (0 when out of range)
//   wr_count          : number of valid words, 0..DEPTH
module regfile_2r1w
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH  = WORD_W,
   parameter int unsigned DEPTH  = RAM8_DEPTH,
   parameter int unsigned AW     = $clog2(DEPTH),
   parameter bit          BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] in,
   input  logic             clear,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             valid_a,
   output logic             valid_b,
   output logic [AW:0]      wr_count
);

   logic [WIDTH-1:0] word_q [DEPTH];
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] waddr_dec;
   logic [DEPTH-1:0] load_vec;
   logic             wr_en;
   logic             new_word;
   logic [AW:0]      wr_count_q;

   // Decode only covers 0..DEPTH-1, so an empty decode means out of range.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign waddr_dec[i] = (waddr == AW'(i));
      assign load_vec[i]  = wr_en & waddr_dec[i];

      reg_word #(
         .WIDTH(WIDTH)
      ) u_reg_word (
         .clk  (clk),
         .rst_n(rst_n),
         .clear(clear),
         .load (load_vec[i]),
         .in   (in),
         .q    (word_q[i]),
         .valid(valid_vec[i])
      );
   end

   assign wr_en    = load & ~clear & (|waddr_dec);
   assign new_word = |(load_vec & ~valid_vec);

   // Only invalid->valid transitions count, so this saturates at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_count_q <= '0;
      end else if (clear) begin
         wr_count_q <= '0;
      end else if (new_word) begin
         wr_count_q <= wr_count_q + (AW+1)'(1);
      end
   end

   assign wr_count = wr_count_q;

   // Read muxes; an address with no matching word leaves the zero default.
   always_comb begin
      out_a   = '0;
      valid_a = 1'b0;
      out_b   = '0;
      valid_b = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (raddr_a == AW'(i)) begin
            out_a   = word_q[i];
            valid_a = valid_vec[i];
         end
         if (raddr_b == AW'(i)) begin
            out_b   = word_q[i];
            valid_b = valid_vec[i];
         end
      end
      if (BYPASS) begin
         if (wr_en && (raddr_a == waddr)) begin
            out_a   = in;
            valid_a = 1'b1;
         end
         if (wr_en && (raddr_b == waddr)) begin
            out_b   = in;
            valid_b = 1'b1;
         end
      end
   end

endmodule : regfile_2r1w

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file built from per-word load registers: one synchronous write port, two combinational read ports, a synchronous clear-all command, optional write-through bypass and per-word valid tracking. It is the generalised successor of the single 16-bit load register and serves as the register bank and RAM8/RAM64 building block of the CPU datapath, feeding the ALU operands.

## Interface
- WIDTH, 16, bits per word
- DEPTH, 8, number of words (≥2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- BYPASS, 0, 1 = a read of the address being written returns write data in the same cycle

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  write enable
- waddr  in  AW  write address
- in  in  WIDTH  write data
- clear  in  1  synchronous clear of all words
- raddr_a  in  AW  read address, port A
- raddr_b  in  AW  read address, port B
- out_a  out  WIDTH  read data, port A
- out_b  out  WIDTH  read data, port B
- valid_a  out  1  word at raddr_a has been written since the last reset/clear
- valid_b  out  1  same, port B
- wr_count  out  AW+1  number of distinct valid words (0..DEPTH)

## Operation
- Storage: DEPTH words of WIDTH bits plus DEPTH valid bits.
- Write: on rising clk with load=1, clear=0 and waddr<DEPTH: word[waddr] ← in, valid[waddr] ← 1.
- Out-of-range write (waddr ≥ DEPTH): ignored; no state change.
- Clear: on rising clk with clear=1: all words ← 0 and all valid ← 0. Clear wins over a simultaneous load.
- Read: out_x = word[raddr_x] combinationally; valid_x = valid[raddr_x].
- Out-of-range read: out_x = 0 and valid_x = 0.
- Both read ports are independent and may address the same word.
- BYPASS=1: if load=1, clear=0 and raddr_x==waddr<DEPTH, then out_x = in and valid_x = 1 combinationally. BYPASS=0: the read returns the old value until after the edge.
- wr_count: increments by 1 on a write to a previously invalid word; unchanged on a rewrite of a valid word or an ignored write; set to 0 on clear.

## Timing
- Reset (rst_n=0, asynchronous): all words 0, all valid 0, wr_count 0. out_a/out_b read 0 and valid_a/valid_b read 0 immediately, independent of clk.
- Reset has priority over load and clear. Reset asserted mid-operation discards the write on that edge.
- The first write is accepted on the first rising edge after rst_n deasserts.
- Write latency: 1 cycle. Data written at edge N is visible on out_x after edge N (same cycle with BYPASS=1).
- Read latency: 0 cycles (combinational from raddr).
- No handshake. A write is accepted on every qualifying edge, with back-to-back writes allowed.
- wr_count saturates naturally at DEPTH because only invalid→valid transitions increment it.

## Structure
- Shared package cpu_pkg holds WORD_W=16 (default WIDTH) and the DEPTH constants RAM8_DEPTH=8 and RAM64_DEPTH=64.
- Sub-module reg_word is a WIDTH-parametrised load register with async active-low reset and synchronous clear, storing one data word plus its valid bit. regfile_2r1w instantiates DEPTH of them with a generate loop.
- The top level contains the write-address decode, the two read muxes with out-of-range masking, the bypass compare, and the wr_count register.

## Test plan
- Reset then read: rst_n=0 with in=16'hFFFF and load=1 → out_a=out_b=0, valid=0, wr_count=0; the write is not taken.
- Write then dual read: write 16'h00FF to addr 3 and 16'hAAAA to addr 5, read A=3 and B=5 → 16'h00FF/16'hAAAA, both valid, wr_count=2. Rewrite addr 3 with 16'h1234 → wr_count stays 2.
- Bypass: BYPASS=1, load=1, waddr=raddr_a=2, in=16'h5A5A → out_a=16'h5A5A before the edge. BYPASS=0, same stimulus → old value before the edge, 16'h5A5A after it.
- Clear vs load: clear=1 and load=1 to addr 1 with 16'hBEEF on the same edge → every word 0, every valid 0, wr_count=0.
- Out of range: DEPTH=6, write 16'h7777 to addr 7 → no state change, wr_count unchanged. Read addr 6 → out=0, valid=0.
- Async reset mid-stream: assert rst_n=0 between edges after 8 writes → outputs drop to 0 immediately, and the next edge while in reset writes nothing.
